// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage; runs loads/stores over a req/ack bus and aborts hung accesses.
// Define MEM_MISALIGN_CHECK_EN to fault misaligned halfword/word accesses instead of issuing them.
`ifndef RADDR_WIDTH
`define RADDR_WIDTH 5
`endif
`ifndef RDATA_WIDTH
`define RDATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef MEM_NOP
`define MEM_NOP 4'h0
`define LB      4'h1
`define LH      4'h2
`define LW      4'h3
`define LBU     4'h4
`define LHU     4'h5
`define SB      4'h6
`define SH      4'h7
`define SW      4'h8
`endif

module mem_stage #(
    parameter int TIMEOUT = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [`RADDR_WIDTH-1:0] reg_waddr_i,
    input  logic                    reg_we_i,
    input  logic [`RDATA_WIDTH-1:0] reg_wdata_i,
    input  logic [`ADDR_WIDTH-1:0]  mem_addr_i,
    input  logic [`DATA_WIDTH-1:0]  mem_data_i,
    input  logic                    mem_we_i,
    input  logic [3:0]              mem_op_i,
    input  logic                    hold_i,
    output logic [`RADDR_WIDTH-1:0] reg_waddr_o,
    output logic                    reg_we_o,
    output logic [`RDATA_WIDTH-1:0] reg_wdata_o,
    output logic                    stallreq_o,
    output logic                    dbus_req_o,
    output logic                    dbus_we_o,
    output logic [`ADDR_WIDTH-1:0]  dbus_addr_o,
    output logic [`DATA_WIDTH-1:0]  dbus_wdata_o,
    output logic [3:0]              dbus_be_o,
    input  logic                    dbus_ack_i,
    input  logic [`DATA_WIDTH-1:0]  dbus_rdata_i,
    output logic                    fault_o,
    output logic [`ADDR_WIDTH-1:0]  fault_addr_o
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t                   r_state;
    logic [CW-1:0]            r_cnt;
    logic [`RDATA_WIDTH-1:0]  r_buf;
    logic                     r_fault;
    logic                     r_fault_pulse;
    logic [`ADDR_WIDTH-1:0]   r_fault_addr;

    logic                     w_is_load, w_is_store, w_is_mem, w_misalign;
    logic [1:0]               w_a;
    logic [3:0]               w_be;
    logic [`DATA_WIDTH-1:0]   w_wdata;
    logic [`RDATA_WIDTH-1:0]  w_load;
    logic [7:0]               w_byte;
    logic [15:0]              w_half;
    logic                     w_unused;

    // The opcode alone decides store vs load; the separate store flag is redundant.
    assign w_unused = mem_we_i;
    assign w_a      = mem_addr_i[1:0];

    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        case (mem_op_i)
            `LB, `LH, `LW, `LBU, `LHU: w_is_load  = 1'b1;
            `SB, `SH, `SW:             w_is_store = 1'b1;
            default: ;
        endcase
    end
    assign w_is_mem = w_is_load | w_is_store;

`ifdef MEM_MISALIGN_CHECK_EN
    assign w_misalign = ((mem_op_i == `LH || mem_op_i == `LHU || mem_op_i == `SH) && w_a[0]) ||
                        ((mem_op_i == `LW || mem_op_i == `SW) && (w_a != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = mem_data_i;
        case (mem_op_i)
            `SB: begin
                w_be    = 4'b0001 << w_a;
                w_wdata = {4{mem_data_i[7:0]}};
            end
            `SH: begin
                w_be    = w_a[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{mem_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_byte = dbus_rdata_i[{w_a, 3'b000} +: 8];
        w_half = w_a[1] ? dbus_rdata_i[31:16] : dbus_rdata_i[15:0];
        case (mem_op_i)
            `LB:     w_load = {{24{w_byte[7]}}, w_byte};
            `LBU:    w_load = {24'b0, w_byte};
            `LH:     w_load = {{16{w_half[15]}}, w_half};
            `LHU:    w_load = {16'b0, w_half};
            default: w_load = dbus_rdata_i;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_buf         <= '0;
            r_fault       <= 1'b0;
            r_fault_pulse <= 1'b0;
            r_fault_addr  <= '0;
        end else begin
            r_fault_pulse <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_is_mem) begin
                        if (w_misalign) begin
                            r_state       <= S_DONE;
                            r_fault       <= 1'b1;
                            r_fault_pulse <= 1'b1;
                            r_fault_addr  <= mem_addr_i;
                        end else if (dbus_ack_i) begin
                            r_buf <= w_load;
                            if (hold_i) begin
                                r_state <= S_DONE;
                                r_fault <= 1'b0;
                            end
                        end else begin
                            r_state <= S_BUSY;
                            r_cnt   <= '0;
                        end
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt + 1'b1;
                    // A late ack on the timeout cycle still completes the access.
                    if (dbus_ack_i) begin
                        r_buf   <= w_load;
                        r_fault <= 1'b0;
                        r_state <= hold_i ? S_DONE : S_IDLE;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_state       <= S_DONE;
                        r_fault       <= 1'b1;
                        r_fault_pulse <= 1'b1;
                        r_fault_addr  <= mem_addr_i;
                    end
                end
                S_DONE: begin
                    if (!hold_i) begin
                        r_state <= S_IDLE;
                        r_fault <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        reg_waddr_o  = '0;
        reg_we_o     = 1'b0;
        reg_wdata_o  = '0;
        stallreq_o   = 1'b0;
        dbus_req_o   = 1'b0;
        dbus_we_o    = 1'b0;
        dbus_addr_o  = '0;
        dbus_wdata_o = '0;
        dbus_be_o    = 4'b0000;
        if (!rst_i) begin
            reg_waddr_o = reg_waddr_i;
            case (r_state)
                S_IDLE: begin
                    if (!w_is_mem) begin
                        reg_we_o    = reg_we_i;
                        reg_wdata_o = reg_wdata_i;
                    end else begin
                        reg_we_o    = w_is_load & reg_we_i & ~w_misalign;
                        reg_wdata_o = w_load;
                        stallreq_o  = w_misalign | ~dbus_ack_i;
                        dbus_req_o  = ~w_misalign;
                    end
                end
                S_BUSY: begin
                    reg_we_o    = w_is_load & reg_we_i;
                    reg_wdata_o = w_load;
                    stallreq_o  = ~dbus_ack_i;
                    dbus_req_o  = 1'b1;
                end
                S_DONE: begin
                    reg_we_o    = w_is_load & reg_we_i & ~r_fault;
                    reg_wdata_o = r_buf;
                end
                default: ;
            endcase
            if (dbus_req_o) begin
                dbus_we_o    = w_is_store;
                dbus_addr_o  = {mem_addr_i[`ADDR_WIDTH-1:2], 2'b00};
                dbus_wdata_o = w_wdata;
                dbus_be_o    = w_be;
            end
        end
    end

    assign fault_o      = r_fault_pulse;
    assign fault_addr_o = r_fault_addr;

endmodule
